// File: rtl/operand_entry.sv
// operand_entry: ASCII key-entry front end building two packed-BCD operands and an operator
// for the calculator arithmetic stage, with a one-cycle start pulse on '='.
module operand_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  output logic [4*MAX_DIGITS-1:0] reg_num1,
  output logic [4*MAX_DIGITS-1:0] reg_num2,
  output logic [2:0]              cnt1,
  output logic [2:0]              cnt2,
  output logic [7:0]              sym,
  output logic                    calc_start,
  output logic                    err,
  output logic [1:0]              phase
);
  localparam int W = 4 * MAX_DIGITS;
  localparam logic [2:0] MAXC = 3'(MAX_DIGITS);
  typedef enum logic [1:0] {NUM1 = 2'd0, NUM2 = 2'd1, DONE = 2'd2} phase_t;
  phase_t       r_phase;
  logic [W-1:0] r_num1, r_num2;
  logic [2:0]   r_cnt1, r_cnt2;
  logic [7:0]   r_sym;
  logic         r_start, r_err;
  logic         w_digit, w_op, w_eq, w_clr;
  logic [3:0]   w_d;
  assign w_digit = key_code >= 8'h30 && key_code <= 8'h39;
  assign w_op    = key_code >= 8'h61 && key_code <= 8'h64;
  assign w_eq    = key_code == 8'h65;
  assign w_clr   = key_code == 8'h66;
  assign w_d     = key_code[3:0];
  always_ff @(posedge clk) begin
    if (rst || (key_valid && w_clr)) begin
      r_phase <= NUM1;
      r_num1  <= '0;
      r_num2  <= '0;
      r_cnt1  <= '0;
      r_cnt2  <= '0;
      r_sym   <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (key_valid) begin
        case (r_phase)
          NUM1: begin
            if (w_digit && r_cnt1 < MAXC) begin
              r_num1 <= {r_num1[W-5:0], w_d};
              r_cnt1 <= r_cnt1 + 3'd1;
            end else if (w_op && r_cnt1 != 3'd0) begin
              r_sym   <= key_code;
              r_phase <= NUM2;
            end
          end
          NUM2: begin
            if (w_digit && r_cnt2 < MAXC) begin
              r_num2 <= {r_num2[W-5:0], w_d};
              r_cnt2 <= r_cnt2 + 3'd1;
            end else if (w_op && r_cnt2 == 3'd0) begin
              r_sym <= key_code;
            end else if (w_eq && r_cnt2 != 3'd0) begin
              r_phase <= DONE;
              // divide by zero flags an error instead of starting the arithmetic stage
              if (r_sym == 8'h64 && r_num2 == '0) r_err <= 1'b1;
              else r_start <= 1'b1;
            end
          end
          DONE: begin
            if (w_digit) begin
              r_num1  <= {{(W-4){1'b0}}, w_d};
              r_num2  <= '0;
              r_cnt1  <= 3'd1;
              r_cnt2  <= '0;
              r_sym   <= '0;
              r_err   <= 1'b0;
              r_phase <= NUM1;
            end
          end
          default: r_phase <= NUM1;
        endcase
      end
    end
  end
  assign reg_num1   = r_num1;
  assign reg_num2   = r_num2;
  assign cnt1       = r_cnt1;
  assign cnt2       = r_cnt2;
  assign sym        = r_sym;
  assign calc_start = r_start;
  assign err        = r_err;
  assign phase      = r_phase;
endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Key-entry front end that sits directly upstream of the calculator arithmetic stage.
- Consumes a stream of ASCII key codes and builds two packed-BCD operands, their digit counts and the operator code.
- Issues a one-cycle start pulse when '=' is pressed with a complete expression.
- Holds every output stable from that pulse until the next expression begins, so the arithmetic stage can sample them freely.

Parameters:
- MAX_DIGITS, 3, maximum digits per operand. Operand width is 4*MAX_DIGITS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  8  ASCII key: '0'-'9' (0x30-0x39) digit; 'a' add, 'b' sub, 'c' mul, 'd' div (0x61-0x64); 'e' (0x65) equals; 'f' (0x66) clear. Any other code is ignored.
- reg_num1  out  4*MAX_DIGITS  operand 1 packed BCD; digit k (k=0 ones) in bits [4k+3:4k].
- reg_num2  out  4*MAX_DIGITS  operand 2, same packing.
- cnt1  out  3  digits entered for operand 1 (0..MAX_DIGITS).
- cnt2  out  3  digits entered for operand 2.
- sym  out  8  latched operator code (0x61-0x64); 0x00 when none.
- calc_start  out  1  one-cycle pulse: expression complete, outputs valid.
- err  out  1  divide-by-zero detected at '='; sticky until next expression.
- phase  out  2  state: 0 NUM1, 1 NUM2, 2 DONE.

Behaviour:
- Reset: reg_num1=0, reg_num2=0, cnt1=0, cnt2=0, sym=0x00, calc_start=0, err=0, phase=NUM1.
- At most one key is processed per cycle. All register updates are visible the cycle after key_valid. calc_start asserts in that same cycle.
- Digit insert: the operand shifts left 4 bits, the new digit goes into [3:0], and the count increments. The most recently typed digit becomes the ones digit.
- Clear ('f'), in any state: same effect as reset on the next cycle.
- NUM1 state:
  - Digit: if cnt1<MAX_DIGITS, insert into reg_num1; otherwise ignore.
  - Operator with cnt1>0: latch sym, go to NUM2.
  - Operator with cnt1=0: ignore.
  - 'e': ignore.
- NUM2 state:
  - Digit: if cnt2<MAX_DIGITS, insert into reg_num2; otherwise ignore.
  - Operator with cnt2=0: replace sym (last operator wins).
  - Operator with cnt2>0: ignore.
  - 'e' with cnt2=0: ignore.
  - 'e' with cnt2>0 and sym=0x64 and reg_num2==0: set err=1, go to DONE, no calc_start.
  - Otherwise 'e': pulse calc_start for exactly 1 cycle, go to DONE.
- DONE state:
  - reg_num1, reg_num2, cnt1, cnt2, sym and err are frozen.
  - Digit: clear all operands, counts, sym and err, then insert the digit as the first digit of reg_num1 and go to NUM1, all in one update.
  - Operator or 'e': ignore.
- Leading zeros are accepted as digits and count toward cntN (e.g. "0","7" gives cnt1=2, reg_num1=0x07).
- calc_start is never asserted in two consecutive cycles. It is never asserted outside the NUM2 to DONE transition.
- Reset asserted mid-entry overrides any concurrent key_valid.
- Unrecognised key codes have no effect in any state.

Test Plan:
- Reset, then keys '1','2','a','3','4','e' -> reg_num1=0x012, cnt1=2, sym=0x61, reg_num2=0x034, cnt2=2; calc_start high exactly one cycle after the 'e' strobe; phase=2.
- Keys '9','8','7','6' (MAX_DIGITS=3) -> 4th digit ignored: reg_num1=0x987, cnt1=3.
- 'a' pressed with cnt1=0, then '5','b','c','2','e' -> first 'a' ignored; sym=0x63 (operator replaced); reg_num2=0x002; calc_start pulses.
- '8','d','0','e' -> err=1, calc_start never asserted, phase=2. Then '4' -> err=0, reg_num1=0x004, cnt1=1, reg_num2=0, sym=0x00, phase=0.
- In DONE after a valid calculation, keys 'a','e' -> all outputs unchanged and no calc_start. Then 'f' -> all outputs at reset values.
- Mid-entry ('3','a','1') assert rst together with key_valid='2' -> next cycle all outputs at reset values, phase=0.
